// File: rtl/spc_pkg.sv
// Shared constants and types for the SPC return-stack controller.
// Pure definitions: no latency, no flow control.
package spc_pkg;
  localparam int SPC_AW = 5;
  localparam int SPC_DW = 19;

  localparam logic [1:0] DBG_RD    = 2'b00;
  localparam logic [1:0] DBG_WR    = 2'b01;
  localparam logic [1:0] DBG_LDPTR = 2'b10;

  typedef enum logic [1:0] {IDLE, DECODE, RWAIT, ACK} spc_state_t;
endpackage

// File: rtl/spc_depth_trk.sv
// SPC stack depth counter with sticky overflow/underflow flags.
// Updates one cycle after upd/load; no backpressure, load has priority.
module spc_depth_trk #(
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          upd,
  input  logic          push,
  input  logic          load,
  input  logic [AW-1:0] load_val,
  output logic [AW:0]   depth,
  output logic          ovf,
  output logic          unf
);
  localparam logic [AW:0] FULL = {1'b1, {AW{1'b0}}};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      depth <= '0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else if (load) begin
      depth <= {1'b0, load_val};
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else if (upd) begin
      // Saturate at the bounds and latch the error instead of wrapping.
      if (push) begin
        if (depth == FULL) ovf <= 1'b1;
        else               depth <= depth + 1'b1;
      end else begin
        if (depth == '0) unf <= 1'b1;
        else             depth <= depth - 1'b1;
      end
    end
  end
endmodule

// File: rtl/spc_arb.sv
// SPC stack RAM/pointer arbiter: microsequencer push/pop vs. debug port; SPC_DEPTH_CHECK_EN adds depth tracking.
// Debug read acks 3 cycles after request, write/load/reserved 2; requests stall while not halted.
module spc_arb
  import spc_pkg::*;
#(
  parameter int AW = SPC_AW,
  parameter int DW = SPC_DW
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          state_fetch,
  input  logic          spcnt,
  input  logic          spush,
  input  logic          srp,
  input  logic          swp,
  input  logic [DW-1:0] spcw,
  input  logic          halted,
  input  logic          dbg_req,
  input  logic [1:0]    dbg_op,
  input  logic [AW-1:0] dbg_adr,
  input  logic [DW-1:0] dbg_wdata,
  output logic          dbg_ack,
  output logic [DW-1:0] dbg_rdata,
  output logic [AW-1:0] ram_adr_a,
  output logic          ram_rden_a,
  input  logic [DW-1:0] ram_q_a,
  output logic [AW-1:0] ram_adr_b,
  output logic          ram_wren_b,
  output logic [DW-1:0] ram_data_b,
  output logic [AW-1:0] spcptr,
  output logic [AW:0]   spc_depth,
  output logic          spc_ovf,
  output logic          spc_unf
);
  spc_state_t state, state_nxt;
  logic       armed;
  logic       cpu_own;
  logic       ptr_upd;
  logic       ld_ptr;

  assign cpu_own = ~halted & (state == IDLE);
  assign ptr_upd = state_fetch & spcnt & (state == IDLE);
  assign ld_ptr  = (state == DECODE) & (dbg_op == DBG_LDPTR);
  assign dbg_ack = (state == ACK);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    ram_adr_a  = spcptr;
    ram_rden_a = cpu_own & srp & ~swp;
    ram_adr_b  = (spcnt & spush) ? spcptr + 1'b1 : spcptr;
    ram_wren_b = cpu_own & swp;
    ram_data_b = spcw;
    case (state)
      IDLE: if (dbg_req & halted & armed) state_nxt = DECODE;
      DECODE: begin
        state_nxt = (dbg_op == DBG_RD) ? RWAIT : ACK;
        if (dbg_op == DBG_RD) begin
          ram_adr_a  = dbg_adr;
          ram_rden_a = 1'b1;
        end else if (dbg_op == DBG_WR) begin
          ram_adr_b  = dbg_adr;
          ram_data_b = dbg_wdata;
          ram_wren_b = 1'b1;
        end
      end
      RWAIT:   state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A request still high at the end of its own ack must drop before it is served again.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)          armed <= 1'b1;
    else if (state == ACK) armed <= ~dbg_req;
    else if (!dbg_req)     armed <= 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     spcptr <= '0;
    else if (ld_ptr)  spcptr <= dbg_adr;
    else if (ptr_upd) spcptr <= spush ? spcptr + 1'b1 : spcptr - 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)            dbg_rdata <= '0;
    else if (state == RWAIT) dbg_rdata <= ram_q_a;
  end

`ifdef SPC_DEPTH_CHECK_EN
  spc_depth_trk #(.AW(AW)) u_depth_trk (
    .clk      (clk),
    .reset_n  (reset_n),
    .upd      (ptr_upd),
    .push     (spush),
    .load     (ld_ptr),
    .load_val (dbg_adr),
    .depth    (spc_depth),
    .ovf      (spc_ovf),
    .unf      (spc_unf)
  );
`else
  assign spc_depth = '0;
  assign spc_ovf   = 1'b0;
  assign spc_unf   = 1'b0;
`endif
endmodule
